// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: funct codes, FSM encoding,
// iteration count.
package mdu_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int ITER_COUNT  = NB_DATA_DEF;
    localparam int CNT_W       = $clog2(ITER_COUNT);

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Shared 2*NB_DATA shift/accumulate register with one shift-add (multiply)
// or restoring trial-subtract (divide) step per cycle. Operands arrive as
// magnitudes; sign handling lives in the top level.
module mdu_iter_core #(
    parameter int NB_DATA = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 div_mode_i,
    input  logic [NB_DATA-1:0]   a_i,
    input  logic [NB_DATA-1:0]   b_i,
    output logic [2*NB_DATA-1:0] acc_o
);

    // acc layout: multiply {partial product, remaining multiplier bits};
    // divide {partial remainder, dividend bits / quotient bits}.
    logic [2*NB_DATA-1:0] acc_q, acc_d;
    logic [NB_DATA-1:0]   b_q, b_d;
    logic [NB_DATA:0]     add_sum;
    logic [NB_DATA:0]     rem_shift;
    logic [NB_DATA:0]     trial;

    // Next accumulator value: load operands, or perform one iteration step.
    always_comb begin
        acc_d     = acc_q;
        b_d       = b_q;
        add_sum   = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + {1'b0, b_q};
        rem_shift = acc_q[2*NB_DATA-1:NB_DATA-1];
        // Remainder stays below the divisor, so a set top bit means borrow.
        trial     = rem_shift - {1'b0, b_q};
        if (load_i) begin
            acc_d = {{NB_DATA{1'b0}}, a_i};
            b_d   = b_i;
        end else if (step_i) begin
            if (!div_mode_i) begin
                if (acc_q[0]) begin
                    acc_d = {add_sum, acc_q[NB_DATA-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*NB_DATA-1:1]};
                end
            end else begin
                if (!trial[NB_DATA]) begin
                    acc_d = {trial[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*NB_DATA-2:0], 1'b0};
                end
            end
        end
    end

    // Accumulator and held multiplicand/divisor registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO. Handshake: a request
// (i_start with a supported funct) is taken only on an edge where the unit
// is idle and i_flush is low; o_done pulses for one cycle when HI/LO have
// just been written by a MULT/DIV/MULTU/DIVU; MTHI/MTLO complete on the
// accept edge with no busy and no done.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [NB_FUNCT-1:0] i_funct,
    input  logic [NB_DATA-1:0]  i_data_a,
    input  logic [NB_DATA-1:0]  i_data_b,
    input  logic                i_flush,
    output logic                o_busy,
    output logic                o_done,
    output logic [NB_DATA-1:0]  o_hi,
    output logic [NB_DATA-1:0]  o_lo
);

    mdu_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 op_div_q;
    logic                 sign_a_q, sign_b_q;
    logic                 b_zero_q;
    logic [NB_DATA-1:0]   a_orig_q;
    logic [NB_DATA-1:0]   hi_q, lo_q;
    logic                 busy_q, done_q;

    logic                 is_mul, is_div, is_signed, accept;
    logic                 a_neg, b_neg;
    logic [NB_DATA-1:0]   a_mag, b_mag;
    logic                 core_load, core_step;
    logic [2*NB_DATA-1:0] acc;
    logic [2*NB_DATA-1:0] prod_fix;
    logic [NB_DATA-1:0]   quo_fix, rem_fix;
    logic [NB_DATA-1:0]   fix_hi, fix_lo;

    // Request decode, magnitude capture and FIX-stage sign correction.
    always_comb begin
        is_mul    = (i_funct == NB_FUNCT'(FUNCT_MULT)) || (i_funct == NB_FUNCT'(FUNCT_MULTU));
        is_div    = (i_funct == NB_FUNCT'(FUNCT_DIV))  || (i_funct == NB_FUNCT'(FUNCT_DIVU));
        is_signed = (i_funct == NB_FUNCT'(FUNCT_MULT)) || (i_funct == NB_FUNCT'(FUNCT_DIV));
        accept    = (state_q == ST_IDLE) && i_start && !i_flush;
        a_neg     = is_signed && i_data_a[NB_DATA-1];
        b_neg     = is_signed && i_data_b[NB_DATA-1];
        a_mag     = a_neg ? -i_data_a : i_data_a;
        b_mag     = b_neg ? -i_data_b : i_data_b;
        core_load = accept && (is_mul || is_div);
        core_step = (state_q == ST_MUL) || (state_q == ST_DIV);

        prod_fix  = (sign_a_q ^ sign_b_q) ? -acc : acc;
        quo_fix   = (sign_a_q ^ sign_b_q) ? -acc[NB_DATA-1:0] : acc[NB_DATA-1:0];
        rem_fix   = sign_a_q ? -acc[2*NB_DATA-1:NB_DATA] : acc[2*NB_DATA-1:NB_DATA];
        if (!op_div_q) begin
            fix_hi = prod_fix[2*NB_DATA-1:NB_DATA];
            fix_lo = prod_fix[NB_DATA-1:0];
        end else if (b_zero_q) begin
            fix_hi = a_orig_q;
            fix_lo = '1;
        end else begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end
    end

    mdu_iter_core #(.NB_DATA(NB_DATA)) u_core (
        .clk_i      (i_clk),
        .rst_n_i    (i_rst_n),
        .load_i     (core_load),
        .step_i     (core_step),
        .div_mode_i (op_div_q),
        .a_i        (a_mag),
        .b_i        (b_mag),
        .acc_o      (acc)
    );

    // Control FSM with registered busy/done and the HI/LO registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            a_orig_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul || is_div) begin
                            state_q  <= is_mul ? ST_MUL : ST_DIV;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            op_div_q <= is_div;
                            sign_a_q <= a_neg;
                            sign_b_q <= b_neg;
                            b_zero_q <= (i_data_b == '0);
                            a_orig_q <= i_data_a;
                        end else if (i_funct == NB_FUNCT'(FUNCT_MTHI)) begin
                            hi_q <= i_data_a;
                        end else if (i_funct == NB_FUNCT'(FUNCT_MTLO)) begin
                            lo_q <= i_data_a;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (i_flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (!i_flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
  import mdu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] data_a, data_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_unit #(.NB_DATA(32), .NB_FUNCT(6)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_funct  (funct),
    .i_data_a (data_a),
    .i_data_b (data_b),
    .i_flush  (flush),
    .o_busy   (busy),
    .o_done   (done),
    .o_hi     (hi),
    .o_lo     (lo)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_m, lo_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p, q64, r64, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (f)
      FUNCT_MULT: begin
        p = sa * sb;
        res = p;
      end
      FUNCT_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        res = p;
      end
      FUNCT_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q64 = sa / sb;
          r64 = sa % sb;
          res = {r64[31:0], q64[31:0]};
        end
      end
      FUNCT_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  // Starts at a negedge; returns at the negedge of the o_done cycle.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int poke_at);
    int busy_cycles;
    int early_done;
    logic [63:0] e;
    exp_q.push_back(ref_model(f, a, b));
    start = 1'b1; funct = f; data_a = a; data_b = b;
    @(posedge clk); @(negedge clk);
    start = 1'b0; data_a = $urandom; data_b = $urandom;
    busy_cycles = 0;
    early_done = 0;
    for (int c = 0; c < 60; c++) begin
      if (!busy) break;
      busy_cycles++;
      if (done) early_done++;
      if (busy_cycles == poke_at) begin
        start = 1'b1; funct = FUNCT_MTLO; data_a = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
    check({tag, "_early_done"}, 32'(early_done), 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    e = exp_q.pop_front();
    hi_m = e[63:32];
    lo_m = e[31:0];
    check({tag, "_hi"}, hi, hi_m);
    check({tag, "_lo"}, lo, lo_m);
  endtask

  task automatic run_mt(input string tag, input logic [5:0] f, input logic [31:0] a);
    start = 1'b1; funct = f; data_a = a; data_b = $urandom;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    if (f == FUNCT_MTHI) hi_m = a; else lo_m = a;
    check({tag, "_hi"}, hi, hi_m);
    check({tag, "_lo"}, lo, lo_m);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_hi"}, hi, hi_m);
    check({tag, "_lo"}, lo, lo_m);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [5:0] ops [4];
    logic [5:0] f;
    logic [31:0] a, b;
    ops[0] = FUNCT_MULT; ops[1] = FUNCT_MULTU; ops[2] = FUNCT_DIV; ops[3] = FUNCT_DIVU;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = '0; data_a = '0; data_b = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(negedge clk);
    check("reset", 32'd0, 32'd0 ^ hi);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed test-plan cases, issued back-to-back in each o_done cycle.
    run_op("mult_m7x6", FUNCT_MULT, 32'hFFFF_FFF9, 32'd6, -1);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFD6);
    run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("multu_hi_const", hi, 32'hFFFF_FFFE);
    check("multu_lo_const", lo, 32'h0000_0001);
    run_op("div_m17_5", FUNCT_DIV, 32'hFFFF_FFEF, 32'd5, 12);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFE);
    run_op("divu_by0", FUNCT_DIVU, 32'h1234_5678, 32'd0, -1);
    check("divu0_lo_const", lo, 32'hFFFF_FFFF);
    check("divu0_hi_const", hi, 32'h1234_5678);
    run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_ovf_lo_const", lo, 32'h8000_0000);
    check("div_ovf_hi_const", hi, 32'h0000_0000);
    run_op("div_by0_neg", FUNCT_DIV, 32'hF000_0001, 32'd0, -1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    // MTHI, then MULT flushed at cycle 10 with an MTLO poke while busy.
    run_mt("mthi", FUNCT_MTHI, 32'hAAAA_0000);
    start = 1'b1; funct = FUNCT_MULT; data_a = 32'd3; data_b = 32'd4;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; funct = FUNCT_MTLO; data_a = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_quiet("flush_mul");
    repeat (40) @(negedge clk);
    check_quiet("flush_mul_later");

    // Flush landing on the FIX edge discards the result.
    start = 1'b1; funct = FUNCT_DIVU; data_a = 32'd100; data_b = 32'd7;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    check("fix_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_quiet("flush_fix");

    // Flush beats a same-cycle MTHI request; unknown funct is ignored.
    start = 1'b1; funct = FUNCT_MTHI; data_a = 32'h1111_1111; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_quiet("flush_mthi");
    start = 1'b1; funct = 6'b100000; data_a = 32'h2222_2222; data_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check_quiet("bad_funct");
    run_mt("mtlo", FUNCT_MTLO, 32'h5555_AAAA);

    // Randomized operations, with corner operands mixed in.
    for (int i = 0; i < 16; i++) begin
      f = ops[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'(($urandom_range(1, 20)));
        3: a = 32'(($urandom_range(0, 50)));
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) run_mt("rand_mt", ($urandom_range(0, 1) == 1) ? FUNCT_MTHI : FUNCT_MTLO, $urandom);
      run_op($sformatf("rand%0d", i), f, a, b, $urandom_range(1, 32));
    end

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; funct = FUNCT_DIV; data_a = 32'd1000; data_b = 32'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hi_m = '0; lo_m = '0;
    check_quiet("reset_mid_div");
    run_op("after_reset", FUNCT_MULTU, 32'd123456, 32'd7890, -1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
